// File: rtl/dtw_sink_collector.sv
// Sink-side FIFO for dtw_core results, drained first-word-fall-through as an AXI4-Stream master.
// Optional packet framer on m_axis_tlast is enabled by defining DTW_SINK_TLAST_EN.
module dtw_sink_collector #(
  parameter int DWIDTH = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sink_fifo_wren,
  input  logic [DWIDTH-1:0] sink_fifo_data,
  output logic              sink_fifo_full,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic [31:0]       pkt_len,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              wr_ok;
  logic              rd_ok;

  // Full and valid come straight from the registered level, so neither depends on tready.
  assign sink_fifo_full = (level == FULL_LEVEL);
  assign m_axis_tvalid  = (level != '0);
  assign m_axis_tdata   = mem[rp];
  assign wr_ok          = sink_fifo_wren & ~sink_fifo_full;
  assign rd_ok          = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= sink_fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= rp + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level <= level + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level <= level - 1'b1;
      end
      // A write offered while full is lost; remember that it happened until reset.
      if (sink_fifo_wren && sink_fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef DTW_SINK_TLAST_EN
  logic [31:0] beat;

  assign m_axis_tlast = m_axis_tvalid & (pkt_len != 32'd0) & (beat == pkt_len - 32'd1);

  // With pkt_len=0 the counter free-runs and wraps; tlast stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (rd_ok) begin
      beat <= m_axis_tlast ? 32'd0 : beat + 32'd1;
    end
  end
`else
  logic pkt_len_unused;

  assign pkt_len_unused = ^pkt_len;
  assign m_axis_tlast   = 1'b0;
`endif

endmodule

// File: tb/tb_dtw_sink_collector.sv
// Scoreboard bench for dtw_sink_collector: directed writes push expected words, a negedge monitor pops and compares.
// Tlast expectations follow DTW_SINK_TLAST_EN when it is defined for the build.
module tb_dtw_sink_collector;

`ifdef DTW_SINK_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sink_fifo_wren;
  logic [31:0] sink_fifo_data;
  logic        sink_fifo_full;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] pkt_len;
  logic [4:0]  level;
  logic        overflow;

  int          errors = 0;
  int          checks = 0;
  int          tlast_count = 0;
  int          base;
  logic [31:0] sb_q[$];
  logic [31:0] model_beat = 32'd0;
  logic        held_valid = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic        exp_last;
  logic [31:0] exp_data;

  dtw_sink_collector #(.DWIDTH(32), .ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .sink_fifo_wren(sink_fifo_wren),
    .sink_fifo_data(sink_fifo_data),
    .sink_fifo_full(sink_fifo_full),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .pkt_len(pkt_len),
    .level(level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; push the word when this write is expected to be accepted.
  task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rdy, input logic accept);
    sink_fifo_wren = wr;
    sink_fifo_data = d;
    m_axis_tready  = rdy;
    if (accept) sb_q.push_back(d);
    tick();
  endtask

  task automatic waitEmpty(input string name);
    int n = 0;
    while (level != 5'd0 && n < 64) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(level), 64'd0);
    checkOutput({name, "_sb"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: inputs change just after posedge, so at negedge tvalid&tready is what the next edge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      model_beat = 32'd0;
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checkOutput("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("hold_tdata", 64'(m_axis_tdata), 64'(held_data));
        checkOutput("hold_tlast", 64'(m_axis_tlast), 64'(held_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        held_valid = 1'b0;
        exp_last = TLAST_EN && (pkt_len != 32'd0) && (model_beat == pkt_len - 32'd1);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
        end else begin
          exp_data = sb_q.pop_front();
          checkOutput("beat_tdata", 64'(m_axis_tdata), 64'(exp_data));
          checkOutput("beat_tlast", 64'(m_axis_tlast), 64'(exp_last));
        end
        if (m_axis_tlast) tlast_count++;
        model_beat = exp_last ? 32'd0 : model_beat + 32'd1;
      end else if (m_axis_tvalid) begin
        held_valid = 1'b1;
        held_data  = m_axis_tdata;
        held_last  = m_axis_tlast;
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sink_fifo_wren = 1'b0;
    sink_fifo_data = 32'd0;
    m_axis_tready = 1'b0;
    pkt_len = 32'd0;
    tick();
    tick();
    checkOutput("rst_full", 64'(sink_fifo_full), 64'd0);
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;

    $display("[TB] fill to full, overflow, full+read boundary");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        checkOutput("pre_full_level", 64'(level), 64'd15);
        checkOutput("pre_full_flag", 64'(sink_fifo_full), 64'd0);
      end
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
    end
    checkOutput("full_flag", 64'(sink_fifo_full), 64'd1);
    checkOutput("full_level", 64'(level), 64'd16);
    checkOutput("full_no_ovf", 64'(overflow), 64'd0);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_level", 64'(level), 64'd16);
    applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b0);
    checkOutput("full_rd_flag", 64'(sink_fifo_full), 64'd0);
    checkOutput("full_rd_level", 64'(level), 64'd15);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    waitEmpty("drain_full");

    $display("[TB] simultaneous read/write at level 5");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1);
    checkOutput("lvl5", 64'(level), 64'd5);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h210 + 32'(i), 1'b1, 1'b1);
      checkOutput("lvl5_hold", 64'(level), 64'd5);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    waitEmpty("drain_lvl5");

    $display("[TB] single write into empty FIFO with tready high");
    applyStimulus(1'b1, 32'hA5A5, 1'b1, 1'b1);
    checkOutput("single_tvalid", 64'(m_axis_tvalid), 64'd1);
    checkOutput("single_tdata", 64'(m_axis_tdata), 64'hA5A5);
    checkOutput("single_level", 64'(level), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("single_tvalid_gone", 64'(m_axis_tvalid), 64'd0);
    checkOutput("single_level_gone", 64'(level), 64'd0);

    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("[TB] framing with pkt_len 3 then 0");
    pkt_len = 32'd3;
    base = tlast_count;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    waitEmpty("drain_pkt3");
    checkOutput("pkt3_tlasts", 64'(tlast_count - base), TLAST_EN ? 64'd2 : 64'd0);
    pkt_len = 32'd0;
    base = tlast_count;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h400 + 32'(i), 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    waitEmpty("drain_pkt0");
    checkOutput("pkt0_tlasts", 64'(tlast_count - base), 64'd0);

    $display("[TB] reset mid-operation");
    pkt_len = 32'd3;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("mid_level", 64'(level), 64'd9);
    checkOutput("mid_overflow", 64'(overflow), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("post_rst_level", 64'(level), 64'd0);
    checkOutput("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("post_rst_full", 64'(sink_fifo_full), 64'd0);
    checkOutput("post_rst_overflow", 64'(overflow), 64'd0);
    base = tlast_count;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h580 + 32'(i), 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    waitEmpty("drain_post_rst");
    checkOutput("post_rst_tlasts", 64'(tlast_count - base), TLAST_EN ? 64'd1 : 64'd0);

    $display("[TB] random tready back-pressure");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h600 + 32'(i), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 100 && level != 5'd0; i++) applyStimulus(1'b0, 32'd0, 1'($urandom_range(0, 1)), 1'b0);
    m_axis_tready = 1'b1;
    waitEmpty("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
